// File: rtl/soml_symbol_mapper.sv
// Bit-serial to 16-QAM symbol-pair mapper: packs 8 bits into four PAM4 levels.
// Optional Gray decoding of each 2-bit field is enabled by SOML_MAPPER_GRAY_MAP_EN.
module soml_symbol_mapper #(
  parameter int unsigned N = 32,
  parameter int unsigned Q = 22
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         bit_in,
  input  logic         bit_valid,
  output logic         bit_ready,
  output logic         sym_valid,
  input  logic         sym_ready,
  output logic [N-1:0] xI1,
  output logic [N-1:0] xQ1,
  output logic [N-1:0] xI2,
  output logic [N-1:0] xQ2,
  output logic [1:0]   idx_I1,
  output logic [1:0]   idx_Q1,
  output logic [1:0]   idx_I2,
  output logic [1:0]   idx_Q2,
  output logic [15:0]  sym_cnt
);

  if (N < Q + 3) begin : g_bad_cfg
    $error("soml_symbol_mapper: N must be at least Q+3");
  end

  logic [2:0] cnt_q;
  // Only seven bits are ever stored; the eighth arrives on bit_in at the completing edge.
  logic [6:0] shreg_q;
  logic [7:0] byte_next;
  logic       accept;
  logic       load;
  logic       retire;
  logic [1:0] k_i1, k_q1, k_i2, k_q2;

  function automatic logic [1:0] field_to_idx(input logic [1:0] f);
`ifdef SOML_MAPPER_GRAY_MAP_EN
    return {f[1], f[1] ^ f[0]};
`else
    return f;
`endif
  endfunction

  // Level m = 2k-3 as an N-bit two's complement integer, scaled by 2^Q.
  function automatic logic [N-1:0] level(input logic [1:0] k);
    logic [N-1:0] m;
    m = {{(N-3){1'b0}}, k, 1'b0} - {{(N-2){1'b0}}, 2'b11};
    return m << Q;
  endfunction

  assign bit_ready = !clr && ((cnt_q != 3'd7) || !sym_valid || sym_ready);
  assign accept    = bit_valid && bit_ready;
  assign byte_next = {shreg_q, bit_in};
  assign load      = accept && (cnt_q == 3'd7);
  assign retire    = sym_valid && sym_ready;

  always_comb begin
    k_i1 = field_to_idx(byte_next[7:6]);
    k_q1 = field_to_idx(byte_next[5:4]);
    k_i2 = field_to_idx(byte_next[3:2]);
    k_q2 = field_to_idx(byte_next[1:0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= 3'd0;
      shreg_q <= 7'd0;
    end else if (clr) begin
      cnt_q   <= 3'd0;
      shreg_q <= 7'd0;
    end else if (accept) begin
      cnt_q   <= cnt_q + 3'd1;
      shreg_q <= byte_next[6:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_valid <= 1'b0;
      xI1       <= '0;
      xQ1       <= '0;
      xI2       <= '0;
      xQ2       <= '0;
      idx_I1    <= 2'd0;
      idx_Q1    <= 2'd0;
      idx_I2    <= 2'd0;
      idx_Q2    <= 2'd0;
    end else if (load) begin
      // A load during a retire keeps sym_valid high: no bubble between pairs.
      sym_valid <= 1'b1;
      xI1       <= level(k_i1);
      xQ1       <= level(k_q1);
      xI2       <= level(k_i2);
      xQ2       <= level(k_q2);
      idx_I1    <= k_i1;
      idx_Q1    <= k_q1;
      idx_I2    <= k_i2;
      idx_Q2    <= k_q2;
    end else if (retire) begin
      sym_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_cnt <= 16'd0;
    end else if (retire) begin
      sym_cnt <= sym_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_soml_symbol_mapper.sv
// Self-checking bench for soml_symbol_mapper: randomized bytes against a table-based model.
module tb_soml_symbol_mapper;

  localparam int unsigned N = 32;
  localparam int unsigned Q = 22;

  typedef struct packed {
    logic [1:0]   i1, q1, i2, q2;
    logic [N-1:0] xi1, xq1, xi2, xq2;
  } sym_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         clr = 1'b0;
  logic         bit_in = 1'b0;
  logic         bit_valid = 1'b0;
  logic         sym_ready = 1'b0;
  logic         bit_ready;
  logic         sym_valid;
  logic [N-1:0] xI1, xQ1, xI2, xQ2;
  logic [1:0]   idx_I1, idx_Q1, idx_I2, idx_Q2;
  logic [15:0]  sym_cnt;

  int   checks = 0;
  int   failures = 0;
  int   stalls = 0;
  int   exp_cnt = 0;
  sym_t obs_q[$];

  soml_symbol_mapper #(.N(N), .Q(Q)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .sym_valid(sym_valid), .sym_ready(sym_ready),
    .xI1(xI1), .xQ1(xQ1), .xI2(xI2), .xQ2(xQ2),
    .idx_I1(idx_I1), .idx_Q1(idx_Q1), .idx_I2(idx_I2), .idx_Q2(idx_Q2),
    .sym_cnt(sym_cnt)
  );

  always #5 clk = ~clk;

  // Records every delivered symbol pair.
  always @(negedge clk) begin
    if (!rst && sym_valid && sym_ready) obs_q.push_back(cur_sym());
  end

  function automatic sym_t cur_sym();
    return '{idx_I1, idx_Q1, idx_I2, idx_Q2, xI1, xQ1, xI2, xQ2};
  endfunction

  function automatic logic [1:0] field_idx(input logic [1:0] f);
    logic [1:0] tab [4];
`ifdef SOML_MAPPER_GRAY_MAP_EN
    tab = '{2'd0, 2'd1, 2'd3, 2'd2};
`else
    tab = '{2'd0, 2'd1, 2'd2, 2'd3};
`endif
    return tab[f];
  endfunction

  function automatic logic [N-1:0] lvl(input logic [1:0] k);
    longint v;
    v = (2 * longint'(k) - 3) * (longint'(1) << Q);
    return v[N-1:0];
  endfunction

  function automatic sym_t exp_sym(input logic [7:0] b);
    sym_t s;
    s.i1 = field_idx(b[7:6]);
    s.q1 = field_idx(b[5:4]);
    s.i2 = field_idx(b[3:2]);
    s.q2 = field_idx(b[1:0]);
    s.xi1 = lvl(s.i1);
    s.xq1 = lvl(s.q1);
    s.xi2 = lvl(s.i2);
    s.xq2 = lvl(s.q2);
    return s;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the bit is accepted.
  task automatic send_bit(input logic b);
    int w;
    w = 0;
    bit_in = b;
    bit_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bit_ready) break;
      w++;
      stalls++;
      if (w > 50) begin
        checks++; failures++;
        $display("FAIL send_bit_timeout: bit_ready=%0b after %0d cycles, required 1", bit_ready, w);
        bit_valid = 1'b0;
        @(posedge clk); #1;
        return;
      end
    end
    @(posedge clk); #1;
    bit_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (sym_valid !== 1'b0 || cur_sym() !== '0 || sym_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_state: valid=%0b sym=%h cnt=%0d, required 0/0/0",
               sym_valid, cur_sym(), sym_cnt);
    end
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bit_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_bit_ready: got %0b, required 1", bit_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_known_byte();
    sym_t e;
`ifdef SOML_MAPPER_GRAY_MAP_EN
    e = '{2'd2, 2'd3, 2'd1, 2'd0, 32'h0040_0000, 32'h00C0_0000, 32'hFFC0_0000, 32'hFF40_0000};
`else
    e = '{2'd3, 2'd2, 2'd1, 2'd0, 32'h00C0_0000, 32'h0040_0000, 32'hFFC0_0000, 32'hFF40_0000};
`endif
    obs_q.delete();
    sym_ready = 1'b1;
    send_byte(8'hE4);
    checks++;
    if (sym_valid !== 1'b1 || cur_sym() !== e) begin
      failures++;
      $display("FAIL known_byte: valid=%0b sym=%h, required 1 %h", sym_valid, cur_sym(), e);
    end
    @(posedge clk); #1;
    exp_cnt = 1;
    checks++;
    if (sym_cnt !== 16'(exp_cnt) || sym_valid !== 1'b0 || obs_q.size() != 1) begin
      failures++;
      $display("FAIL known_byte_retire: cnt=%0d valid=%0b n=%0d, required %0d 0 1",
               sym_cnt, sym_valid, obs_q.size(), exp_cnt);
    end
  endtask

  task automatic test_stream();
    logic [7:0] bytes [16];
    obs_q.delete();
    stalls = 0;
    sym_ready = 1'b1;
    for (int i = 0; i < 16; i++) bytes[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) send_byte(bytes[i]);
    @(posedge clk); #1;
    exp_cnt += 16;
    checks++;
    if (stalls != 0 || obs_q.size() != 16) begin
      failures++;
      $display("FAIL stream_flow: stalls=%0d symbols=%0d, required 0 16", stalls, obs_q.size());
    end
    for (int i = 0; i < 16 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_sym(bytes[i])) begin
        failures++;
        $display("FAIL stream_sym[%0d]: got %h, required %h", i, obs_q[i], exp_sym(bytes[i]));
      end
    end
    checks++;
    if (sym_cnt !== 16'(exp_cnt)) begin
      failures++;
      $display("FAIL stream_cnt: got %0d, required %0d", sym_cnt, exp_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] a, b;
    a = 8'($urandom);
    b = 8'($urandom);
    obs_q.delete();
    sym_ready = 1'b0;
    send_byte(a);
    stalls = 0;
    for (int i = 7; i >= 1; i--) send_bit(b[i]);
    checks++;
    if (stalls != 0) begin
      failures++;
      $display("FAIL bp_partial_stall: stalls=%0d, required 0", stalls);
    end
    bit_in = b[0];
    bit_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bit_ready !== 1'b0 || sym_valid !== 1'b1 || cur_sym() !== exp_sym(a)) begin
        failures++;
        $display("FAIL bp_hold[%0d]: ready=%0b valid=%0b sym=%h, required 0 1 %h",
                 c, bit_ready, sym_valid, cur_sym(), exp_sym(a));
      end
    end
    @(posedge clk); #1;
    sym_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bit_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_ready: got %0b, required 1", bit_ready);
    end
    @(posedge clk); #1;
    bit_valid = 1'b0;
    checks++;
    if (sym_valid !== 1'b1 || cur_sym() !== exp_sym(b) || obs_q.size() != 1) begin
      failures++;
      $display("FAIL bp_swap: valid=%0b sym=%h n=%0d, required 1 %h 1",
               sym_valid, cur_sym(), obs_q.size(), exp_sym(b));
    end
    @(posedge clk); #1;
    exp_cnt += 2;
    checks++;
    if (obs_q.size() != 2 || sym_valid !== 1'b0 || sym_cnt !== 16'(exp_cnt)) begin
      failures++;
      $display("FAIL bp_drain: n=%0d valid=%0b cnt=%0d, required 2 0 %0d",
               obs_q.size(), sym_valid, sym_cnt, exp_cnt);
    end else begin
      checks++;
      if (obs_q[0] !== exp_sym(a) || obs_q[1] !== exp_sym(b)) begin
        failures++;
        $display("FAIL bp_order: got %h %h, required %h %h",
                 obs_q[0], obs_q[1], exp_sym(a), exp_sym(b));
      end
    end
  endtask

  task automatic test_clr();
    logic [7:0] c;
    c = 8'($urandom);
    obs_q.delete();
    sym_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_bit(1'($urandom));
    bit_in = 1'b1;
    bit_valid = 1'b1;
    clr = 1'b1;
    @(negedge clk);
    checks++;
    if (bit_ready !== 1'b0) begin
      failures++;
      $display("FAIL clr_ready: got %0b, required 0", bit_ready);
    end
    @(posedge clk); #1;
    clr = 1'b0;
    bit_valid = 1'b0;
    send_byte(c);
    @(posedge clk); #1;
    exp_cnt += 1;
    checks++;
    if (obs_q.size() != 1 || sym_cnt !== 16'(exp_cnt)) begin
      failures++;
      $display("FAIL clr_count: n=%0d cnt=%0d, required 1 %0d", obs_q.size(), sym_cnt, exp_cnt);
    end else begin
      checks++;
      if (obs_q[0] !== exp_sym(c)) begin
        failures++;
        $display("FAIL clr_sym: got %h, required %h", obs_q[0], exp_sym(c));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d, e;
    d = 8'($urandom);
    e = 8'($urandom);
    sym_ready = 1'b0;
    send_byte(d);
    send_bit(1'b1);
    send_bit(1'b0);
    checks++;
    if (sym_valid !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_pre: valid=%0b, required 1", sym_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (sym_valid !== 1'b0 || cur_sym() !== '0 || sym_cnt !== 16'd0) begin
      failures++;
      $display("FAIL rstmid_async: valid=%0b sym=%h cnt=%0d, required 0/0/0",
               sym_valid, cur_sym(), sym_cnt);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bit_ready !== 1'b1 || sym_valid !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_release: ready=%0b valid=%0b, required 1 0", bit_ready, sym_valid);
    end
    @(posedge clk); #1;
    obs_q.delete();
    sym_ready = 1'b1;
    send_byte(e);
    @(posedge clk); #1;
    checks++;
    if (obs_q.size() != 1 || sym_cnt !== 16'd1) begin
      failures++;
      $display("FAIL rstmid_after: n=%0d cnt=%0d, required 1 1", obs_q.size(), sym_cnt);
    end else begin
      checks++;
      if (obs_q[0] !== exp_sym(e)) begin
        failures++;
        $display("FAIL rstmid_sym: got %h, required %h", obs_q[0], exp_sym(e));
      end
    end
  endtask

  initial begin
    test_reset();
    test_known_byte();
    test_stream();
    test_backpressure();
    test_clr();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/soml_symbol_mapper.md
Name: soml_symbol_mapper

Overview:
- Transmit-side counterpart of the SOML min-distance detector: packs a bit-serial stream into 16-QAM symbol pairs and maps each 2-bit index to a PAM4 level from {-3,-1,+1,+3}.
- Produces one set of xI1/xQ1/xI2/xQ2 samples per 8 input bits, in the same signed fixed-point format the detector consumes.
- Sits between the bit source and the channel model/detector.
- Uses valid/ready handshakes on both sides.

Parameters:
- N, 32, output sample width in bits (signed two's complement).
- Q, 22, fractional bits. Level m is encoded as m*2^Q. Constraint N >= Q+3.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear: discards partially collected bits; output register untouched.
- bit_in  input  1  serial data bit.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_ready  output  1  mapper accepts bit_in this cycle.
- sym_valid  output  1  symbol-pair outputs are valid.
- sym_ready  input  1  downstream accepts the symbol pair.
- xI1, xQ1, xI2, xQ2  output  N  mapped levels (signed, Q fractional bits).
- idx_I1, idx_Q1, idx_I2, idx_Q2  output  2  natural level index 0..3 (0=-3, 1=-1, 2=+1, 3=+3), used for loopback against detector min_idx.
- sym_cnt  output  16  count of symbol pairs delivered; increments on each sym_valid&&sym_ready; wraps 0xFFFF->0.

Behaviour:
- Reset (rst high, asynchronous): bit counter=0, shift register=0, sym_valid=0, all x* outputs=0, idx_* outputs=0, sym_cnt=0. bit_ready is 1 in the first cycle after reset.
- Bit accept: bit_valid && bit_ready.
  - Bit is shifted into an 8-bit register, MSB first: first accepted bit of a group becomes b[7].
  - 3-bit counter runs 0..7.
- Field mapping of the byte: b[7:6] -> I1, b[5:4] -> Q1, b[3:2] -> I2, b[1:0] -> Q2.
- Group complete: on acceptance of the 8th bit (counter==7), in the same edge:
  - outputs load from the completed byte (including the bit being accepted);
  - sym_valid goes 1;
  - counter wraps to 0.
  - Latency: sym_valid is high in the cycle after the 8th bit handshake.
- Backpressure: bit_ready = (counter != 7) || !sym_valid || sym_ready.
  - Bits 1..7 of the next group are collected while a symbol waits.
  - Only the 8th bit stalls.
  - Simultaneous 8th-bit accept and sym_valid&&sym_ready: new symbol loads, sym_valid stays 1, no bubble.
- Output stability: while sym_valid && !sym_ready, all x*, idx_* and sym_valid hold.
- Output retirement: sym_valid && sym_ready with no new load clears sym_valid; data outputs keep their last value.
- Level mapping: level index k -> m = 2k-3.
  - x = m sign-extended and shifted left by Q.
  - With defaults: -3 = 0xFF400000, -1 = 0xFFC00000, +1 = 0x00400000, +3 = 0x00C00000.
- bit_valid with bit_ready low: bit is not consumed; the source must hold it.
- clr:
  - counter=0; partial bits dropped.
  - clr has priority over a bit accept in the same cycle; that bit is not consumed and bit_ready is forced 0.
  - sym_valid, outputs and sym_cnt are unaffected.
- Reset mid-group or mid-stall: everything returns to reset values immediately; pending symbol is lost.

Optional Feature:
- Macro: SOML_MAPPER_GRAY_MAP_EN.
- Defined: each 2-bit field g is Gray-decoded before level mapping. Field -> index: 00->0, 01->1, 11->2, 10->3. So 00 maps to -3, 01 to -1, 11 to +1, 10 to +3. Adjacent levels differ in one bit.
- Undefined: field value is used directly as the index (natural binary).
- In both cases, idx_* report the natural level index k actually used for x*.

Test Plan:
- Reset, then bits 1,1,1,0,0,1,0,0 (byte 0xE4), sym_ready=1, macro off -> one cycle after the 8th bit: sym_valid=1, xI1=0x00C00000, xQ1=0x00400000, xI2=0xFFC00000, xQ2=0xFF400000; idx=3,2,1,0; sym_cnt=1 the following cycle.
- Same byte 0xE4 with SOML_MAPPER_GRAY_MAP_EN -> fields 11,10,01,00 give idx=2,3,1,0; xI1=0x00400000, xQ1=0x00C00000, xI2=0xFFC00000, xQ2=0xFF400000.
- Hold sym_ready=0 after the first symbol, keep bit_valid=1 -> 7 bits of the next group accepted, then bit_ready=0 on the 8th; outputs stable. Raise sym_ready -> 8th bit accepted in that cycle and sym_valid stays 1 with new data.
- Send 5 bits, pulse clr together with a 6th bit_valid -> that bit not consumed; the following 8 bits form a fresh symbol and the prior 5 bits never appear.
- Continuous stream of 16 bytes with sym_ready=1 -> 16 symbols, one per 8 bit-cycles, no stall; sym_cnt=16.
- Assert rst while sym_valid=1 and sym_ready=0 -> sym_valid, x*, idx_* and sym_cnt all 0 immediately; bit_ready=1 in the first cycle after release.
